// File: rtl/ascon_pack.sv
// Shared ASCON types: 5x64 state, column count and p_S sequencer states.
package ascon_pack;

  localparam int NB_COLS = 64;

  typedef logic [0:4][0:NB_COLS-1] type_state;

  typedef enum logic {
    IDLE,
    RUN
  } type_sub_fsm;

endpackage

// File: rtl/sub_layer_seq_sbox.sv
// Bitsliced 5-bit ASCON sbox; bit 0 of sbox_i/sbox_o is the x0 row.
module sbox (
  input  logic [0:4] sbox_i,
  output logic [0:4] sbox_o
);

  logic a0, a1, a2, a3, a4;
  logic t0, t1, t2, t3, t4;
  logic b0, b1, b2, b3, b4;

  always_comb begin
    a0 = sbox_i[0] ^ sbox_i[4];
    a1 = sbox_i[1];
    a2 = sbox_i[2] ^ sbox_i[1];
    a3 = sbox_i[3];
    a4 = sbox_i[4] ^ sbox_i[3];
    t0 = ~a0 & a1;
    t1 = ~a1 & a2;
    t2 = ~a2 & a3;
    t3 = ~a3 & a4;
    t4 = ~a4 & a0;
    b0 = a0 ^ t1;
    b1 = a1 ^ t2;
    b2 = a2 ^ t3;
    b3 = a3 ^ t4;
    b4 = a4 ^ t0;
    sbox_o[1] = b1 ^ b0;
    sbox_o[0] = b0 ^ b4;
    sbox_o[3] = b3 ^ b2;
    sbox_o[2] = ~b2;
    sbox_o[4] = b4;
  end

endmodule

// File: rtl/sub_layer_seq.sv
// Serialized ASCON substitution layer, COLS_PER_CYCLE sboxes per clock.
// Optional abort input enabled by defining SUB_LAYER_ABORT_EN.
module sub_layer_seq
  import ascon_pack::*;
#(
  parameter int COLS_PER_CYCLE = 4
) (
  input  logic      clock_i,
  input  logic      reset_i,
  input  logic      start_i,
`ifdef SUB_LAYER_ABORT_EN
  input  logic      abort_i,
`endif
  input  type_state state_i,
  output type_state state_o,
  output logic      busy_o,
  output logic      done_o
);

  localparam int N  = COLS_PER_CYCLE;
  localparam int NG = NB_COLS / N;
  localparam int CW = (NG > 1) ? $clog2(NG) : 1;

  type_sub_fsm fsm_q, fsm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  type_state state_q, state_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic [5:0] base;
  logic [0:4][0:N-1] grp_i, grp_o;
  logic last;
  logic abort;

  assign base = 6'(int'(cnt_q) * N);
  assign last = (cnt_q == CW'(NG - 1));

`ifdef SUB_LAYER_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  for (genvar k = 0; k < 5; k++) begin : g_row
    assign grp_i[k] = state_q[k][base +: N];
  end

  for (genvar g = 0; g < N; g++) begin : g_sbox
    logic [0:4] s_in, s_out;
    assign s_in = {grp_i[0][g], grp_i[1][g], grp_i[2][g],
                   grp_i[3][g], grp_i[4][g]};
    sbox u_sbox (
      .sbox_i(s_in),
      .sbox_o(s_out)
    );
    assign grp_o[0][g] = s_out[0];
    assign grp_o[1][g] = s_out[1];
    assign grp_o[2][g] = s_out[2];
    assign grp_o[3][g] = s_out[3];
    assign grp_o[4][g] = s_out[4];
  end

  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        if (start_i) begin
          state_d = state_i;
          cnt_d   = '0;
          fsm_d   = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        // Abort wins over completion and leaves the partial state visible.
        if (abort) begin
          fsm_d  = IDLE;
          busy_d = 1'b0;
          cnt_d  = '0;
        end else begin
          for (int k = 0; k < 5; k++) begin
            state_d[k][base +: N] = grp_o[k];
          end
          if (last) begin
            fsm_d  = IDLE;
            busy_d = 1'b0;
            done_d = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        fsm_d  = IDLE;
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fsm_q   <= IDLE;
      cnt_q   <= '0;
      state_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign state_o = state_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule
